// File: rtl/midi_rx_ring_writer.sv
// Wishbone master that stores received MIDI bytes into a circular region of a byte-wide RAM
// and publishes the committed write pointer; bytes that cannot be stored are dropped and flagged.
module midi_rx_ring_writer #(
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter int         DEPTH_LOG2  = 4,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic [7:0]            wb_adr_o,
  output logic [7:0]            wb_dat_o,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic                  wb_ack_i,
  input  logic [DEPTH_LOG2:0]   rd_ptr_i,
  output logic [DEPTH_LOG2:0]   wr_ptr_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  ovf_o,
  output logic                  err_o,
  input  logic                  flag_clr_i
);

  localparam int PW = DEPTH_LOG2 + 1;
  localparam logic [PW:0] RING_SIZE = (PW + 1)'(1) << DEPTH_LOG2;
  localparam logic [7:0]  TMO_LAST  = 8'(ACK_TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t          state;
  logic [7:0]      hold_q;
  logic [7:0]      adr_q;
  logic [7:0]      tmo_cnt;
  logic            stb_q;
  logic [PW-1:0]   wr_ptr;
  logic            ovf_q;
  logic            err_q;

  logic            in_flight;
  logic [PW:0]     occupancy;
  logic            ack_now;
  logic            accept;
  logic            drop;
  logic            timeout;
  logic [PW-1:0]   wr_ptr_inc;
  logic [PW-1:0]   ptr_next;

  // Occupancy counts the byte on the bus so the ring can never be overcommitted.
  // One extra bit keeps a runaway read pointer from wrapping occupancy back below full.
  assign in_flight  = (state == WRITE);
  assign count_o    = wr_ptr - rd_ptr_i;
  assign occupancy  = {1'b0, count_o} + (PW + 1)'(in_flight);
  assign full_o     = (occupancy >= RING_SIZE);

  assign ack_now    = in_flight && wb_ack_i;
  assign wr_ptr_inc = wr_ptr + PW'(1);
  assign ptr_next   = ack_now ? wr_ptr_inc : wr_ptr;

  // While a write is pending without ack, a new byte has nowhere to go. On the ack edge the
  // in-flight byte is already counted in occupancy, so full_o equals "full after the commit".
  assign accept     = rx_valid_i && !full_o && (!in_flight || wb_ack_i);
  assign drop       = rx_valid_i && !accept;
  assign timeout    = in_flight && !wb_ack_i && (tmo_cnt == TMO_LAST);

  // NOTE: all state below is updated with non-blocking assignments so every register samples
  // the pre-edge values of its peers; blocking here would create order-dependent behaviour.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      hold_q  <= '0;
      adr_q   <= '0;
      tmo_cnt <= '0;
      stb_q   <= 1'b0;
      wr_ptr  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // A new event on the same edge as a clear wins.
      ovf_q <= drop    | (ovf_q & ~flag_clr_i);
      err_q <= timeout | (err_q & ~flag_clr_i);

      if (ack_now) begin
        wr_ptr <= wr_ptr_inc;
      end

      if (accept) begin
        hold_q  <= rx_data_i;
        adr_q   <= BASE_ADDR + 8'(ptr_next[DEPTH_LOG2-1:0]);
        tmo_cnt <= '0;
        stb_q   <= 1'b1;
        state   <= WRITE;
      end else if (ack_now || timeout) begin
        tmo_cnt <= '0;
        stb_q   <= 1'b0;
        state   <= IDLE;
      end else if (in_flight) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

  assign wb_adr_o = adr_q;
  assign wb_dat_o = hold_q;
  assign wb_stb_o = stb_q;
  assign wb_cyc_o = stb_q;
  assign wb_we_o  = stb_q;
  assign wr_ptr_o = wr_ptr;
  assign ovf_o    = ovf_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_midi_rx_ring_writer.sv
// Directed bench for midi_rx_ring_writer: two instances (base 8'h00 and 8'h40) share stimulus
// and each acks combinationally from its own strobe when ack_en is set.
module tb_midi_rx_ring_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [4:0] rd_ptr;
  logic       flag_clr;
  logic       ack_en;

  logic [7:0] adr0, dat0, adr1, dat1;
  logic       we0, stb0, cyc0, full0, ovf0, err0, ack0;
  logic       we1, stb1, cyc1, full1, ovf1, err1, ack1;
  logic [4:0] wr0, cnt0, wr1, cnt1;

  int total = 0;
  int bad   = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];

  assign ack0 = ack_en & stb0;
  assign ack1 = ack_en & stb1;

  always #5 clk = ~clk;

  midi_rx_ring_writer #(.BASE_ADDR(8'h00), .DEPTH_LOG2(4), .ACK_TIMEOUT(15)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .wb_adr_o(adr0), .wb_dat_o(dat0), .wb_we_o(we0), .wb_stb_o(stb0), .wb_cyc_o(cyc0),
    .wb_ack_i(ack0), .rd_ptr_i(rd_ptr), .wr_ptr_o(wr0), .count_o(cnt0), .full_o(full0),
    .ovf_o(ovf0), .err_o(err0), .flag_clr_i(flag_clr)
  );

  midi_rx_ring_writer #(.BASE_ADDR(8'h40), .DEPTH_LOG2(4), .ACK_TIMEOUT(15)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .wb_adr_o(adr1), .wb_dat_o(dat1), .wb_we_o(we1), .wb_stb_o(stb1), .wb_cyc_o(cyc1),
    .wb_ack_i(ack1), .rd_ptr_i(rd_ptr), .wr_ptr_o(wr1), .count_o(cnt1), .full_o(full1),
    .ovf_o(ovf1), .err_o(err1), .flag_clr_i(flag_clr)
  );

  // Record each committed write mid-cycle, when stb and the combinational ack are settled.
  always @(negedge clk) begin
    if (!rst && stb0 && ack0) q0.push_back({adr0, dat0});
    if (!rst && stb1 && ack1) q1.push_back({adr1, dat1});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    flag_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic test_reset();
    rd_ptr = 5'd0;
    ack_en = 1'b1;
    rx_data = 8'h00;
    do_reset();
    total++; if ({stb0, cyc0, we0} !== 3'b000) begin bad++; $display("FAIL reset_bus: got %b want 000", {stb0, cyc0, we0}); end
    total++; if ({adr0, dat0} !== 16'h0000) begin bad++; $display("FAIL reset_adr_dat: got %h want 0000", {adr0, dat0}); end
    total++; if (wr0 !== 5'd0) begin bad++; $display("FAIL reset_wr_ptr: got %0d want 0", wr0); end
    total++; if ({ovf0, err0, full0} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {ovf0, err0, full0}); end
    total++; if (cnt0 !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    total++; if (adr1 !== 8'h00) begin bad++; $display("FAIL reset_adr1: got %h want 00", adr1); end
  endtask

  task automatic test_basic();
    send_byte(8'h90);
    total++; if ({stb0, cyc0, we0} !== 3'b111) begin bad++; $display("FAIL basic_latency: got %b want 111", {stb0, cyc0, we0}); end
    total++; if (adr0 !== 8'h00 || dat0 !== 8'h90) begin bad++; $display("FAIL basic_first_bus: got %h/%h want 00/90", adr0, dat0); end
    tick();
    total++; if (stb0 !== 1'b0) begin bad++; $display("FAIL basic_stb_drop: got %b want 0", stb0); end
    repeat (3) tick();
    send_byte(8'h3C);
    repeat (4) tick();
    total++; if (q0.size() !== 2) begin bad++; $display("FAIL basic_nwrites: got %0d want 2", q0.size()); end
    else begin
      total++; if (q0[0] !== 16'h0090) begin bad++; $display("FAIL basic_w0: got %h want 0090", q0[0]); end
      total++; if (q0[1] !== 16'h013C) begin bad++; $display("FAIL basic_w1: got %h want 013C", q0[1]); end
    end
    total++; if (q1.size() !== 2 || q1[0] !== 16'h4090) begin bad++; $display("FAIL basic_base40: got size %0d want 2 with 4090 first", q1.size()); end
    total++; if (wr0 !== 5'd2) begin bad++; $display("FAIL basic_wr_ptr: got %0d want 2", wr0); end
    total++; if (cnt0 !== 5'd2) begin bad++; $display("FAIL basic_count: got %0d want 2", cnt0); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp;
    do_reset();
    rd_ptr = 5'd0;
    ack_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_byte(8'hC0 + 8'(i));
      tick();
      rd_ptr = 5'(i + 1);
      tick();
    end
    total++; if (q1.size() !== 20) begin bad++; $display("FAIL wrap_nwrites: got %0d want 20", q1.size()); end
    for (int i = 0; i < 20 && i < q1.size(); i++) begin
      exp = {8'h40 + 8'(i % 16), 8'hC0 + 8'(i)};
      total++; if (q1[i] !== exp) begin bad++; $display("FAIL wrap_entry%0d: got %h want %h", i, q1[i], exp); end
    end
    total++; if (wr1 !== 5'd20) begin bad++; $display("FAIL wrap_wr_ptr: got %0d want 20", wr1); end
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL wrap_ovf: got %b want 0", ovf1); end
  endtask

  task automatic test_overflow();
    do_reset();
    rd_ptr = 5'd0;
    ack_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h10 + 8'(i));
      tick();
      tick();
    end
    total++; if (full0 !== 1'b1 || cnt0 !== 5'd16) begin bad++; $display("FAIL ovf_full16: got full=%b count=%0d want 1/16", full0, cnt0); end
    total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL ovf_before: got %b want 0", ovf0); end
    send_byte(8'hEE);
    tick();
    total++; if (ovf0 !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf0); end
    total++; if (q0.size() !== 16 || wr0 !== 5'd16) begin bad++; $display("FAIL ovf_stored: got %0d/%0d want 16/16", q0.size(), wr0); end
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", ovf0); end
    flag_clr = 1'b1;
    send_byte(8'hEF);
    flag_clr = 1'b0;
    total++; if (ovf0 !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", ovf0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rd_ptr = 5'd0;
    ack_en = 1'b1;
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rx_data = 8'(i);
      tick();
      total++; if (stb0 !== (i < 16)) begin bad++; $display("FAIL b2b_stb%0d: got %b want %b", i, stb0, (i < 16)); end
      total++; if (ovf0 !== (i >= 16)) begin bad++; $display("FAIL b2b_ovf%0d: got %b want %b", i, ovf0, (i >= 16)); end
    end
    rx_valid = 1'b0;
    total++; if (q0.size() !== 16) begin bad++; $display("FAIL b2b_nwrites: got %0d want 16", q0.size()); end
    for (int i = 0; i < 16 && i < q0.size(); i++) begin
      total++; if (q0[i] !== {8'(i), 8'(i)}) begin bad++; $display("FAIL b2b_entry%0d: got %h want %h", i, q0[i], {8'(i), 8'(i)}); end
    end
    total++; if (wr0 !== 5'd16 || full0 !== 1'b1) begin bad++; $display("FAIL b2b_final: got wr=%0d full=%b want 16/1", wr0, full0); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    rd_ptr = 5'd0;
    ack_en = 1'b0;
    send_byte(8'h55);
    n = 0;
    while (stb0 && n < 40) begin
      n++;
      tick();
    end
    total++; if (n !== 15) begin bad++; $display("FAIL tmo_cycles: got %0d want 15", n); end
    total++; if (err0 !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", err0); end
    total++; if (wr0 !== 5'd0 || q0.size() !== 0) begin bad++; $display("FAIL tmo_no_commit: got wr=%0d writes=%0d want 0/0", wr0, q0.size()); end
    ack_en = 1'b1;
    send_byte(8'h66);
    repeat (2) tick();
    total++; if (q0.size() !== 1 || q0[0] !== 16'h0066) begin bad++; $display("FAIL tmo_recover: got size %0d want 1 with 0066", q0.size()); end
    total++; if (wr0 !== 5'd1 || err0 !== 1'b1) begin bad++; $display("FAIL tmo_after: got wr=%0d err=%b want 1/1", wr0, err0); end
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    total++; if (err0 !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %b want 0", err0); end
  endtask

  task automatic test_reset_midwrite();
    ack_en = 1'b0;
    send_byte(8'h77);
    repeat (16) tick();
    send_byte(8'h78);
    send_byte(8'h79);
    total++; if ({stb0, ovf0, err0} !== 3'b111 || wr0 !== 5'd1) begin bad++; $display("FAIL midrst_setup: got %b wr=%0d want 111 wr=1", {stb0, ovf0, err0}, wr0); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (stb0 !== 1'b0 || stb1 !== 1'b0) begin bad++; $display("FAIL midrst_stb: got %b%b want 00", stb0, stb1); end
    total++; if (wr0 !== 5'd0) begin bad++; $display("FAIL midrst_wr_ptr: got %0d want 0", wr0); end
    total++; if ({ovf0, err0} !== 2'b00) begin bad++; $display("FAIL midrst_flags: got %b want 00", {ovf0, err0}); end
    total++; if ({adr0, dat0} !== 16'h0000) begin bad++; $display("FAIL midrst_adr_dat: got %h want 0000", {adr0, dat0}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_reset_midwrite();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
